// File: rtl/wash_cycle_sequencer.sv
// Washer program sequencer: fill/wash/drain/spin passes, rinse repeats, done beep.
// Owns the pause toggle, door interlock and the remaining-time counters.
module wash_cycle_sequencer #(
  parameter int TICK_DRAIN   = 2,
  parameter int TICK_MIDSPIN = 2,
  parameter int TICK_BEEP    = 5
) (
  input  logic       cp,
  input  logic       resetBtn,
  input  logic       runBtn,
  input  logic       doorOpen,
  input  logic       tick,
  input  logic [2:0] waterLevel,
  input  logic [5:0] washTime,
  input  logic [5:0] rinseTime,
  input  logic [1:0] rinseCount,
  input  logic [5:0] spinTime,
  output logic [2:0] phase,
  output logic       paused,
  output logic       inWaterLED,
  output logic       washLED,
  output logic       outWaterLED,
  output logic       spinLED,
  output logic [5:0] phaseRemain,
  output logic [9:0] remainSec,
  output logic [1:0] passIdx,
  output logic       beep,
  output logic       doneLED
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_DRAIN = 3'd3,
    S_SPIN  = 3'd4,
    S_DONE  = 3'd5
  } phase_e;

  localparam logic [5:0] TD = 6'(TICK_DRAIN);
  localparam logic [5:0] TM = 6'(TICK_MIDSPIN);
  localparam logic [5:0] TB = 6'(TICK_BEEP);

  phase_e     phase_q, phase_d;
  logic       paused_q, paused_d;
  logic       blink_q, blink_d;
  logic [5:0] pr_q, pr_d;
  logic [9:0] rs_q, rs_d;
  logic [1:0] pass_q, pass_d;
  logic [2:0] f_q, f_d;
  logic [5:0] w_q, w_d, r_q, r_d, s_q, s_d;
  logic [1:0] n_q, n_d;
  logic [3:0] led_q, led_d;

  // Zero-valued times are clamped to one tick.
  logic [2:0] f_in;
  logic [5:0] w_in, r_in, s_in;
  logic [9:0] n10, prog_len;

  assign f_in = (waterLevel == 3'd0) ? 3'd1 : waterLevel;
  assign w_in = (washTime   == 6'd0) ? 6'd1 : washTime;
  assign r_in = (rinseTime  == 6'd0) ? 6'd1 : rinseTime;
  assign s_in = (spinTime   == 6'd0) ? 6'd1 : spinTime;
  assign n10  = {8'd0, rinseCount};
  assign prog_len = (n10 + 10'd1) * ({7'd0, f_in} + {4'd0, TD})
                  + {4'd0, w_in} + n10 * {4'd0, r_in}
                  + n10 * {4'd0, TM} + {4'd0, s_in};

  logic       etick;
  logic [3:0] onehot;

  always_comb begin
    phase_d  = phase_q;
    paused_d = paused_q;
    pr_d     = pr_q;
    rs_d     = rs_q;
    pass_d   = pass_q;
    f_d      = f_q;
    w_d      = w_q;
    r_d      = r_q;
    s_d      = s_q;
    n_d      = n_q;
    etick    = 1'b0;
    onehot   = 4'd0;
    case (phase_q)
      S_IDLE: begin
        paused_d = 1'b0;
        pass_d   = 2'd0;
        pr_d     = 6'd0;
        rs_d     = 10'd0;
        if (runBtn && !doorOpen) begin
          phase_d = S_FILL;
          f_d = f_in; w_d = w_in; r_d = r_in; s_d = s_in; n_d = rinseCount;
          pr_d = {3'd0, f_in};
          rs_d = prog_len;
        end
      end
      S_FILL, S_WASH, S_DRAIN, S_SPIN: begin
        paused_d = doorOpen | (runBtn ? ~paused_q : paused_q);
        // Judging the tick against the new pause state makes a pause edge
        // swallow it and a resume edge consume it.
        etick = tick & ~paused_d;
        if (etick) begin
          rs_d = rs_q - 10'd1;
          if (pr_q == 6'd1) begin
            case (phase_q)
              S_FILL: begin
                phase_d = S_WASH;
                pr_d    = (pass_q == 2'd0) ? w_q : r_q;
              end
              S_WASH: begin
                phase_d = S_DRAIN;
                pr_d    = TD;
              end
              S_DRAIN: begin
                phase_d = S_SPIN;
                pr_d    = (pass_q == n_q) ? s_q : TM;
              end
              default: begin
                if (pass_q < n_q) begin
                  phase_d = S_FILL;
                  pass_d  = pass_q + 2'd1;
                  pr_d    = {3'd0, f_q};
                end else begin
                  phase_d = S_DONE;
                  pr_d    = TB;
                end
              end
            endcase
          end else begin
            pr_d = pr_q - 6'd1;
          end
        end
      end
      S_DONE: begin
        paused_d = 1'b0;
        if (runBtn || doorOpen || (tick && pr_q == 6'd1)) begin
          phase_d = S_IDLE;
          pr_d    = 6'd0;
          rs_d    = 10'd0;
          pass_d  = 2'd0;
        end else if (tick) begin
          pr_d = pr_q - 6'd1;
        end
      end
      default: phase_d = S_IDLE;
    endcase

    blink_d = (paused_d && !paused_q) ? 1'b0 : (tick ? ~blink_q : blink_q);

    case (phase_d)
      S_FILL:  onehot = 4'b0001;
      S_WASH:  onehot = 4'b0010;
      S_DRAIN: onehot = 4'b0100;
      S_SPIN:  onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    led_d = onehot ^ (onehot & {4{paused_d & blink_d}});
  end

  always_ff @(posedge cp) begin
    if (resetBtn) begin
      phase_q  <= S_IDLE;
      paused_q <= 1'b0;
      blink_q  <= 1'b0;
      pr_q     <= 6'd0;
      rs_q     <= 10'd0;
      pass_q   <= 2'd0;
      f_q      <= 3'd1;
      w_q      <= 6'd1;
      r_q      <= 6'd1;
      s_q      <= 6'd1;
      n_q      <= 2'd0;
      led_q    <= 4'd0;
    end else begin
      phase_q  <= phase_d;
      paused_q <= paused_d;
      blink_q  <= blink_d;
      pr_q     <= pr_d;
      rs_q     <= rs_d;
      pass_q   <= pass_d;
      f_q      <= f_d;
      w_q      <= w_d;
      r_q      <= r_d;
      s_q      <= s_d;
      n_q      <= n_d;
      led_q    <= led_d;
    end
  end

  assign phase       = phase_q;
  assign paused      = paused_q;
  assign inWaterLED  = led_q[0];
  assign washLED     = led_q[1];
  assign outWaterLED = led_q[2];
  assign spinLED     = led_q[3];
  assign phaseRemain = pr_q;
  assign remainSec   = rs_q;
  assign passIdx     = pass_q;
  assign beep        = (phase_q == S_DONE);
  assign doneLED     = (phase_q == S_DONE);

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer with hand-computed phase/time sequences.
module tb_wash_cycle_sequencer;

  logic       cp = 1'b0;
  logic       resetBtn = 1'b0, runBtn = 1'b0, doorOpen = 1'b0, tick = 1'b0;
  logic [2:0] waterLevel = 3'd0;
  logic [5:0] washTime = 6'd0, rinseTime = 6'd0, spinTime = 6'd0;
  logic [1:0] rinseCount = 2'd0;
  logic [2:0] phase;
  logic       paused, inWaterLED, washLED, outWaterLED, spinLED, beep, doneLED;
  logic [5:0] phaseRemain;
  logic [9:0] remainSec;
  logic [1:0] passIdx;

  int vecs = 0;
  int errs = 0;

  wash_cycle_sequencer dut (
    .cp(cp), .resetBtn(resetBtn), .runBtn(runBtn), .doorOpen(doorOpen), .tick(tick),
    .waterLevel(waterLevel), .washTime(washTime), .rinseTime(rinseTime),
    .rinseCount(rinseCount), .spinTime(spinTime), .phase(phase), .paused(paused),
    .inWaterLED(inWaterLED), .washLED(washLED), .outWaterLED(outWaterLED),
    .spinLED(spinLED), .phaseRemain(phaseRemain), .remainSec(remainSec),
    .passIdx(passIdx), .beep(beep), .doneLED(doneLED)
  );

  always #5 cp = ~cp;

  task automatic step(input logic t, input logic r, input logic rst);
    @(negedge cp);
    tick = t; runBtn = r; resetBtn = rst;
    @(posedge cp);
    #1;
    tick = 1'b0; runBtn = 1'b0; resetBtn = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 1'b1);
    vecs++;
    if ({phase, paused, inWaterLED, washLED, outWaterLED, spinLED, phaseRemain, remainSec,
         passIdx, beep, doneLED} !== 31'd0) begin
      errs++;
      $display("FAIL reset: phase=%0d paused=%b leds=%b%b%b%b pr=%0d rs=%0d pass=%0d beep=%b done=%b, want all 0",
               phase, paused, inWaterLED, washLED, outWaterLED, spinLED, phaseRemain, remainSec,
               passIdx, beep, doneLED);
    end
  endtask

  task automatic test_basic_program();
    int ep[11];
    int epr[11];
    logic [3:0] eled;
    ep  = '{1, 2, 2, 2, 3, 3, 4, 4, 4, 4, 5};
    epr = '{1, 3, 2, 1, 2, 1, 4, 3, 2, 1, 5};
    waterLevel = 3'd2; washTime = 6'd3; rinseCount = 2'd0; spinTime = 6'd4; rinseTime = 6'd9;
    step(1'b0, 1'b1, 1'b0);
    vecs++;
    if (phase !== 3'd1 || phaseRemain !== 6'd2 || remainSec !== 10'd11 || inWaterLED !== 1'b1) begin
      errs++;
      $display("FAIL start: phase=%0d pr=%0d rs=%0d fillLED=%b, want 1/2/11/1",
               phase, phaseRemain, remainSec, inWaterLED);
    end
    waterLevel = 3'd7; washTime = 6'd40;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, 1'b0, 1'b0);
      eled = (ep[i] >= 1 && ep[i] <= 4) ? (4'b0001 << (ep[i] - 1)) : 4'b0000;
      vecs++;
      if (phase !== 3'(ep[i]) || phaseRemain !== 6'(epr[i]) || remainSec !== 10'(10 - i) ||
          {spinLED, outWaterLED, washLED, inWaterLED} !== eled) begin
        errs++;
        $display("FAIL prog tick %0d: phase=%0d pr=%0d rs=%0d leds=%b, want %0d/%0d/%0d/%b",
                 i + 1, phase, phaseRemain, remainSec, {spinLED, outWaterLED, washLED, inWaterLED},
                 ep[i], epr[i], 10 - i, eled);
      end
    end
    vecs++;
    if (beep !== 1'b1 || doneLED !== 1'b1) begin
      errs++;
      $display("FAIL done flags: beep=%b doneLED=%b, want 1/1", beep, doneLED);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      vecs++;
      if (phase !== 3'd5 || phaseRemain !== 6'(4 - i)) begin
        errs++;
        $display("FAIL beep count %0d: phase=%0d pr=%0d, want 5/%0d", i, phase, phaseRemain, 4 - i);
      end
    end
    step(1'b1, 1'b0, 1'b0);
    vecs++;
    if (phase !== 3'd0 || beep !== 1'b0 || doneLED !== 1'b0) begin
      errs++;
      $display("FAIL done exit: phase=%0d beep=%b, want 0/0", phase, beep);
    end
  endtask

  task automatic test_rinse_passes();
    int sph[12];
    int sln[12];
    int sps[12];
    int rem;
    sph = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 4};
    sln = '{1, 1, 2, 2, 1, 1, 2, 2, 1, 1, 2, 1};
    sps = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
    waterLevel = 3'd1; washTime = 6'd1; rinseTime = 6'd1; spinTime = 6'd1; rinseCount = 2'd2;
    step(1'b0, 1'b1, 1'b0);
    rem = 17;
    for (int s = 0; s < 12; s++) begin
      vecs++;
      if (phase !== 3'(sph[s]) || phaseRemain !== 6'(sln[s]) || passIdx !== 2'(sps[s]) ||
          remainSec !== 10'(rem)) begin
        errs++;
        $display("FAIL rinse seg %0d: phase=%0d pr=%0d pass=%0d rs=%0d, want %0d/%0d/%0d/%0d",
                 s, phase, phaseRemain, passIdx, remainSec, sph[s], sln[s], sps[s], rem);
      end
      for (int k = 0; k < sln[s]; k++) begin
        step(1'b1, 1'b0, 1'b0);
        rem--;
      end
    end
    vecs++;
    if (phase !== 3'd5 || remainSec !== 10'd0) begin
      errs++;
      $display("FAIL rinse done: phase=%0d rs=%0d, want 5/0", phase, remainSec);
    end
    step(1'b0, 1'b1, 1'b0);
    vecs++;
    if (phase !== 3'd0) begin
      errs++;
      $display("FAIL done runBtn exit: phase=%0d, want 0", phase);
    end
  endtask

  task automatic test_pause_blink();
    waterLevel = 3'd2; washTime = 6'd3; rinseCount = 2'd0; spinTime = 6'd4;
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    vecs++;
    if (phase !== 3'd2 || phaseRemain !== 6'd2 || paused !== 1'b1 || washLED !== 1'b1 ||
        remainSec !== 10'd8) begin
      errs++;
      $display("FAIL pause entry: phase=%0d pr=%0d paused=%b washLED=%b rs=%0d, want 2/2/1/1/8",
               phase, phaseRemain, paused, washLED, remainSec);
    end
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      vecs++;
      if (phaseRemain !== 6'd2 || remainSec !== 10'd8 || washLED !== 1'(i % 2 == 0)) begin
        errs++;
        $display("FAIL pause tick %0d: pr=%0d rs=%0d washLED=%b, want 2/8/%b",
                 i, phaseRemain, remainSec, washLED, 1'(i % 2 == 0));
      end
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    vecs++;
    if (paused !== 1'b0 || phaseRemain !== 6'd1 || washLED !== 1'b1) begin
      errs++;
      $display("FAIL resume: paused=%b pr=%0d washLED=%b, want 0/1/1", paused, phaseRemain, washLED);
    end
  endtask

  task automatic test_door_interlock();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    doorOpen = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    vecs++;
    if (phase !== 3'd4 || paused !== 1'b1 || phaseRemain !== 6'd4) begin
      errs++;
      $display("FAIL door pause: phase=%0d paused=%b pr=%0d, want 4/1/4", phase, paused, phaseRemain);
    end
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    vecs++;
    if (paused !== 1'b1 || phaseRemain !== 6'd4) begin
      errs++;
      $display("FAIL door run ignored: paused=%b pr=%0d, want 1/4", paused, phaseRemain);
    end
    doorOpen = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    vecs++;
    if (paused !== 1'b1) begin
      errs++;
      $display("FAIL door closed stays paused: paused=%b, want 1", paused);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    vecs++;
    if (paused !== 1'b0 || phaseRemain !== 6'd3 || remainSec !== 10'd3 || spinLED !== 1'b1) begin
      errs++;
      $display("FAIL door resume: paused=%b pr=%0d rs=%0d spinLED=%b, want 0/3/3/1",
               paused, phaseRemain, remainSec, spinLED);
    end
  endtask

  task automatic test_same_edge_and_reset();
    step(1'b1, 1'b1, 1'b0);
    vecs++;
    if (paused !== 1'b1 || phaseRemain !== 6'd3) begin
      errs++;
      $display("FAIL run+tick pause: paused=%b pr=%0d, want 1/3", paused, phaseRemain);
    end
    step(1'b1, 1'b1, 1'b0);
    vecs++;
    if (paused !== 1'b0 || phaseRemain !== 6'd2) begin
      errs++;
      $display("FAIL run+tick resume: paused=%b pr=%0d, want 0/2", paused, phaseRemain);
    end
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    vecs++;
    if (phase !== 3'd1) begin
      errs++;
      $display("FAIL restart: phase=%0d, want 1", phase);
    end
    step(1'b1, 1'b1, 1'b1);
    vecs++;
    if ({phase, paused, inWaterLED, washLED, outWaterLED, spinLED, phaseRemain, remainSec,
         passIdx, beep, doneLED} !== 31'd0) begin
      errs++;
      $display("FAIL reset dominates: phase=%0d paused=%b pr=%0d rs=%0d, want all 0",
               phase, paused, phaseRemain, remainSec);
    end
  endtask

  task automatic test_clamp_and_door_idle();
    waterLevel = 3'd0; washTime = 6'd0; rinseCount = 2'd0; spinTime = 6'd1;
    step(1'b0, 1'b1, 1'b0);
    vecs++;
    if (phase !== 3'd1 || phaseRemain !== 6'd1 || remainSec !== 10'd5) begin
      errs++;
      $display("FAIL clamp start: phase=%0d pr=%0d rs=%0d, want 1/1/5", phase, phaseRemain, remainSec);
    end
    step(1'b1, 1'b0, 1'b0);
    vecs++;
    if (phase !== 3'd2 || phaseRemain !== 6'd1) begin
      errs++;
      $display("FAIL clamp wash: phase=%0d pr=%0d, want 2/1", phase, phaseRemain);
    end
    step(1'b1, 1'b0, 1'b0);
    vecs++;
    if (phase !== 3'd3 || phaseRemain !== 6'd2 || remainSec !== 10'd3) begin
      errs++;
      $display("FAIL clamp drain: phase=%0d pr=%0d rs=%0d, want 3/2/3", phase, phaseRemain, remainSec);
    end
    step(1'b0, 1'b0, 1'b1);
    doorOpen = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    vecs++;
    if (phase !== 3'd0 || remainSec !== 10'd0) begin
      errs++;
      $display("FAIL door idle start: phase=%0d rs=%0d, want 0/0", phase, remainSec);
    end
    doorOpen = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_program();
    test_rinse_passes();
    test_pause_blink();
    test_door_interlock();
    test_same_edge_and_reset();
    test_clamp_and_door_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
- Program sequencer for the washer datapath: fill, wash, drain, spin, then repeated rinse passes, then a done/beep phase.
- Driven by the 1 Hz tick and the debounced run/door buttons from the top level.
- Feeds phase LEDs and remaining-time counts to the display controllers.
- Owns pause/resume and the door-safety interlock.

Parameters:
- TICK_DRAIN, 2, drain phase length in ticks (1..15)
- TICK_MIDSPIN, 2, spin length after every non-final pass (1..15)
- TICK_BEEP, 5, done-beep length in ticks (1..15)

Ports:
- cp  in  1  system clock; all logic on the rising edge
- resetBtn  in  1  reset; synchronous, active-high
- runBtn  in  1  one-cycle pulse; start from IDLE, otherwise toggles pause
- doorOpen  in  1  level; door open
- tick  in  1  one-cycle 1 Hz strobe
- waterLevel  in  3  fill ticks; 0 treated as 1
- washTime  in  6  wash agitation ticks; 0 treated as 1
- rinseTime  in  6  rinse agitation ticks; 0 treated as 1
- rinseCount  in  2  number of rinse passes (0..3)
- spinTime  in  6  final spin ticks; 0 treated as 1
- phase  out  3  IDLE=0 FILL=1 WASH=2 DRAIN=3 SPIN=4 DONE=5
- paused  out  1  timers frozen (user pause or door)
- inWaterLED, washLED, outWaterLED, spinLED  out  1 each  active phase indicator
- phaseRemain  out  6  ticks left in current phase
- remainSec  out  10  ticks left in whole program
- passIdx  out  2  0 = wash pass, k = k-th rinse
- beep  out  1  high during DONE
- doneLED  out  1  high during DONE

Behaviour:
- Reset: phase=IDLE, paused=0, all LEDs 0, phaseRemain=0, remainSec=0, passIdx=0, beep=0, doneLED=0. Reset dominates every other input on the same edge.
- All config inputs are latched on the start edge only; changes mid-program are ignored.
- Effective tick (etick): tick & running & !paused & !doorOpen.
- IDLE:
  - runBtn & !doorOpen -> FILL on the next edge, with paused=0 and passIdx=0.
  - Load phaseRemain=F, where F=max(waterLevel,1).
  - Load remainSec = (n+1)*(F+TICK_DRAIN) + W + n*R + n*TICK_MIDSPIN + S, where n=rinseCount and W/R/S are the clamped times.
  - runBtn while doorOpen: ignored.
- Countdown:
  - On each etick, phaseRemain and remainSec decrement by 1.
  - When etick arrives with phaseRemain==1, take the transition on that edge and load the next phase length. There is no zero-length cycle.
- Transitions:
  - FILL -> WASH: load W if passIdx==0, else R.
  - WASH -> DRAIN: load TICK_DRAIN.
  - DRAIN -> SPIN: load S if passIdx==n, else TICK_MIDSPIN.
  - SPIN -> FILL with passIdx+1 when passIdx<n; SPIN -> DONE otherwise.
  - remainSec reaches 0 exactly on entry to DONE.
- DONE:
  - beep=1, doneLED=1, phaseRemain loaded with TICK_BEEP and counted down on raw tick (pause does not apply).
  - Leave to IDLE when the count expires, on runBtn, or on doorOpen; the earliest event wins.
- Pause:
  - runBtn in FILL..SPIN toggles paused.
  - runBtn while doorOpen=1 is ignored (cannot resume with the door open).
  - If runBtn and tick arrive on the same edge, the toggle applies and the tick is not consumed when pausing. When resuming, the tick is consumed.
- Door interlock:
  - doorOpen=1 in FILL..SPIN forces paused=1 on the next edge.
  - Closing the door leaves paused=1; the user must press runBtn to resume.
- LEDs:
  - Exactly the LED matching phase is high.
  - While paused, the active LED blinks: its value is XORed with a toggle flop flipped on every raw tick, cleared on pause entry.
  - IDLE: all LEDs 0.
- Widths: remainSec arithmetic is done in 10 bits. Max program (n=3, all 63, F=7, params 15) = 4*22+63+189+45+63 = 448, so no overflow.

Test Plan:
- Reset, waterLevel=2, washTime=3, rinseCount=0, spinTime=4, runBtn -> phase 1,2,3,4,5 with durations 2,3,2,4 ticks; remainSec starts at 11 and reaches 0 on DONE entry; beep for 5 ticks, then IDLE.
- rinseCount=2, rinseTime=1, others 1 -> passIdx 0,1,2; mid spins last 2 ticks, final spin 1 tick; remainSec starts at 3*(1+2)+1+2+4+1=17.
- Pause in WASH with phaseRemain=2: 5 ticks -> phaseRemain stays 2 and washLED blinks; runBtn -> resumes with washLED steady.
- doorOpen during SPIN -> paused=1; runBtn with door open ignored; close door then runBtn -> resume with phaseRemain unchanged.
- runBtn and tick on the same edge while running -> pause set, phaseRemain unchanged; resetBtn mid-FILL together with runBtn -> all outputs at reset values on the next edge.
- washTime=0, waterLevel=0 -> each treated as 1 tick; runBtn with doorOpen=1 in IDLE -> stays IDLE.
